// File: rtl/pipelined_cla_subtractor.sv
// Pipelined a - b (= a + ~b + 1), one carry-lookahead block per stage,
// registered inter-block carry and valid/ready with bubble collapsing.
module pipelined_cla_subtractor #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_diff,
   output logic             out_zero,
   output logic             out_overflow
);

   localparam int STAGES = WIDTH / BLOCK;
   localparam int LAST   = STAGES - 1;

   if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_param
      $error("WIDTH must be a multiple of BLOCK, 1 <= BLOCK <= WIDTH");
   end

   // Returns {carry_out, sum} of one block of a + nb + cin.
   function automatic logic [BLOCK:0] cla_block(
      input logic [BLOCK-1:0] a,
      input logic [BLOCK-1:0] nb,
      input logic             cin
   );
      logic [BLOCK-1:0] g;
      logic [BLOCK-1:0] p;
      logic [BLOCK:0]   c;
      g    = a & nb;
      p    = a | nb;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < BLOCK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[BLOCK], a ^ nb ^ c[BLOCK-1:0]};
   endfunction

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] c_q;
   logic [WIDTH-1:0]  a_q  [STAGES];
   logic [WIDTH-1:0]  nb_q [STAGES];
   logic [WIDTH-1:0]  r_q  [STAGES];
   logic              z_q;
   logic              o_q;

   logic [STAGES-1:0] v_s;
   logic [STAGES-1:0] c_s;
   logic [STAGES-1:0] c_n;
   logic [WIDTH-1:0]  a_s  [STAGES];
   logic [WIDTH-1:0]  nb_s [STAGES];
   logic [WIDTH-1:0]  r_s  [STAGES];
   logic [WIDTH-1:0]  r_n  [STAGES];
   logic [BLOCK:0]    blk;
   logic [STAGES:0]   load;
   logic              ovf_n;

   always_comb begin
      load         = '0;
      load[STAGES] = out_ready;
      for (int k = LAST; k >= 0; k--) begin
         load[k] = ~v_q[k] | load[k+1];
      end
   end

   // Stage 0 is fed by the ports, stage k by the stage k-1 registers.
   always_comb begin
      v_s[0]  = in_valid;
      a_s[0]  = in_a;
      nb_s[0] = ~in_b;
      r_s[0]  = '0;
      c_s[0]  = 1'b1;
      for (int k = 1; k < STAGES; k++) begin
         v_s[k]  = v_q[k-1];
         a_s[k]  = a_q[k-1];
         nb_s[k] = nb_q[k-1];
         r_s[k]  = r_q[k-1];
         c_s[k]  = c_q[k-1];
      end
   end

   always_comb begin
      blk = '0;
      for (int k = 0; k < STAGES; k++) begin
         blk = cla_block(a_s[k][k*BLOCK +: BLOCK],
                         nb_s[k][k*BLOCK +: BLOCK], c_s[k]);
         r_n[k]                   = r_s[k];
         r_n[k][k*BLOCK +: BLOCK] = blk[BLOCK-1:0];
         c_n[k]                   = blk[BLOCK];
      end
   end

   assign ovf_n = (a_s[LAST][WIDTH-1] == nb_s[LAST][WIDTH-1])
                & (r_n[LAST][WIDTH-1] != a_s[LAST][WIDTH-1]);

   // Carries reset high so the presented borrow reads 0 out of reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v_q <= '0;
         c_q <= '1;
         z_q <= 1'b0;
         o_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               v_q[k]  <= v_s[k];
               c_q[k]  <= c_n[k];
               a_q[k]  <= a_s[k];
               nb_q[k] <= nb_s[k];
               r_q[k]  <= r_n[k];
            end
         end
         if (load[LAST]) begin
            z_q <= ~|r_n[LAST];
            o_q <= ovf_n;
         end
      end
   end

   assign in_ready     = load[0] & ~i_rst;
   assign out_valid    = v_q[LAST];
   assign out_diff     = {~c_q[LAST], r_q[LAST]};
   assign out_zero     = z_q;
   assign out_overflow = o_q;

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Directed bench for pipelined_cla_subtractor: three instances
// (BLOCK = 8, 32, 1) exercised one at a time against hand values.
module tb_pipelined_cla_subtractor;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [34:0] exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [2:0]  vld;
   logic [2:0]  rdy;
   logic [2:0]  ir;
   logic [2:0]  ov;
   logic [2:0]  oz;
   logic [2:0]  oo;
   logic [31:0] a_in [3];
   logic [31:0] b_in [3];
   logic [32:0] diff [3];

   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t stim_q[$];
   vec_t exp_q[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pipelined_cla_subtractor #(
         .WIDTH(32),
         .BLOCK(g == 0 ? 8 : (g == 1 ? 32 : 1))
      ) u_dut (
         .i_clk       (clk),
         .i_rst       (rst),
         .in_valid    (vld[g]),
         .in_ready    (ir[g]),
         .in_a        (a_in[g]),
         .in_b        (b_in[g]),
         .out_valid   (ov[g]),
         .out_ready   (rdy[g]),
         .out_diff    (diff[g]),
         .out_zero    (oz[g]),
         .out_overflow(oo[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic int stg(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 32);
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic ovf, input logic zero,
                               input logic [32:0] d);
      vec_t v;
      v.a   = a;
      v.b   = b;
      v.exp = {ovf, zero, d};
      return v;
   endfunction

   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] d;
      logic        ovf;
      d   = {1'b0, a} - {1'b0, b};
      ovf = (a[31] != b[31]) && (d[31] != a[31]);
      return mk(a, b, ovf, d[31:0] == 32'd0, d);
   endfunction

   function automatic logic [34:0] seen(input int d);
      return {oo[d], oz[d], diff[d]};
   endfunction

   task automatic drive(input int d, input int pv, input int pr);
      if (stim_q.size() != 0 && $urandom_range(99) < pv) begin
         vld[d]  = 1'b1;
         a_in[d] = stim_q[0].a;
         b_in[d] = stim_q[0].b;
      end else begin
         vld[d] = 1'b0;
      end
      rdy[d] = ($urandom_range(99) < pr);
   endtask

   // Entered and left just after a rising edge.
   task automatic run(input int d, input int pv, input int pr,
                      input int budget, output int cyc);
      logic fin;
      logic fout;
      cyc = 0;
      drive(d, pv, pr);
      while ((stim_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         fin  = vld[d] & ir[d];
         fout = ov[d] & rdy[d];
         if (ov[d]) begin
            if (exp_q.size() == 0) chk("spurious_valid", ov[d], 0);
            else chk(fout ? "result" : "stall_hold", seen(d), exp_q[0].exp);
         end
         if (fout && exp_q.size() != 0) void'(exp_q.pop_front());
         @(posedge clk);
         #1;
         if (fin) exp_q.push_back(stim_q.pop_front());
         drive(d, pv, pr);
      end
      chk("drain_left", stim_q.size() + exp_q.size(), 0);
      stim_q.delete();
      exp_q.delete();
      vld[d] = 1'b0;
      rdy[d] = 1'b1;
   endtask

   task automatic lat_test(input int d, input vec_t v);
      rdy[d]  = 1'b1;
      vld[d]  = 1'b1;
      a_in[d] = v.a;
      b_in[d] = v.b;
      @(negedge clk);
      chk("lat_accept", ir[d], 1);
      @(posedge clk);
      #1;
      vld[d] = 1'b0;
      for (int i = 1; i <= stg(d); i++) begin
         @(negedge clk);
         chk(i == stg(d) ? "lat_valid" : "lat_early", ov[d], i == stg(d));
         if (i < stg(d)) begin
            @(posedge clk);
            #1;
         end
      end
      chk("lat_result", seen(d), v.exp);
      @(posedge clk);
      #1;
   endtask

   task automatic bp_test(input int d);
      int   acc;
      int   cyc;
      logic fin;
      acc = 0;
      for (int i = 0; i < 8; i++) stim_q.push_back(model($urandom, $urandom));
      rdy[d] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         vld[d]  = 1'b1;
         a_in[d] = stim_q[0].a;
         b_in[d] = stim_q[0].b;
         @(negedge clk);
         fin = vld[d] & ir[d];
         @(posedge clk);
         #1;
         if (fin) begin
            acc++;
            exp_q.push_back(stim_q.pop_front());
         end
      end
      vld[d] = 1'b0;
      chk("bp_accepted", acc, (stg(d) < 8) ? stg(d) : 8);
      @(negedge clk);
      chk("bp_in_ready", ir[d], stg(d) > 8);
      @(posedge clk);
      #1;
      run(d, 100, 100, 200, cyc);
      // 32-stage case: oldest pair sits in stage 8 here, reaches the end 23 cycles later.
      chk("bp_drain_cycles", cyc, (stg(d) > 8) ? 31 : 8);
   endtask

   task automatic rst_test(input int d);
      int   cyc;
      logic fin;
      rdy[d] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vld[d]  = 1'b1;
         a_in[d] = 32'h1111_0000 + i;
         b_in[d] = 32'h0000_0001;
         @(negedge clk);
         fin = vld[d] & ir[d];
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", ir[d], 0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      vld[d] = 1'b0;
      rdy[d] = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", ov[d], 0);
      chk("rst_out_data", seen(d), 0);
      @(posedge clk);
      #1;
      stim_q.push_back(mk(32'd7, 32'd2, 1'b0, 1'b0, 33'd5));
      run(d, 100, 100, 100, cyc);
   endtask

   task automatic load_directed();
      stim_q.push_back(mk(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 33'h1_FFFF_FFFF));
      stim_q.push_back(mk(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, 33'h0_0000_00FF));
      stim_q.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 33'h0_7FFF_FFFF));
      stim_q.push_back(mk(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 33'h0_0000_0000));
      stim_q.push_back(mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 33'h1_8000_0000));
      stim_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 33'h0_0000_0000));
      stim_q.push_back(mk(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, 33'h0_FFFE_0001));
   endtask

   initial begin
      int          cyc;
      logic [31:0] ra;
      rst = 1'b1;
      vld = '0;
      rdy = '1;
      for (int d = 0; d < 3; d++) begin
         a_in[d] = '0;
         b_in[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("reset_in_ready", ir[d], 0);
         chk("reset_out_valid", ov[d], 0);
         chk("reset_out_diff", diff[d], 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int d = 0; d < 3; d++) begin
         lat_test(d, mk(32'd5, 32'd3, 1'b0, 1'b0, 33'd2));
         load_directed();
         run(d, 100, 100, 200, cyc);
         load_directed();
         run(d, 50, 50, 500, cyc);
         bp_test(d);
         for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            stim_q.push_back(model(ra, (i % 7 == 0) ? ra : $urandom));
         end
         run(d, 50, 50, 4000, cyc);
         rst_test(d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
